// File: rtl/ysyx_22050019_axi_sram_if.sv
// AXI-lite-style bus bundle between the LSU master and the SRAM slave.
// Carries the AW/W/B write channels and the AR/R read channels.
//   master modport: drives valids, addresses, write data/strobe and the b/r readies.
//   slave  modport: drives the aw/w/ar readies, b/r valids, responses and read data.
interface ysyx_22050019_axi_sram_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;

    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;

    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;

    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;

    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/ysyx_22050019_axi_sram.sv
// Single-port SRAM slave terminating the LSU's AXI-lite AW/W/B and AR/R channels.
// Word-addressed 64-bit array, byte-strobed writes, address-aligned reads,
// OKAY (2'b00) / DECERR (2'b11) responses. Read and write channels are
// independent FSMs sharing the array.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave side of ysyx_22050019_axi_sram_if (AW/W/B, AR/R channels)
//
// Optional feature: define YSYX_22050019_AXI_SRAM_DELAY_EN to add 0-3 random
// extra cycles (from a 4-bit LFSR) before b_valid and r_valid.
module ysyx_22050019_axi_sram #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int unsigned           RD_LATENCY = 1
) (
    input logic                           clk,
    input logic                           rst,
    ysyx_22050019_axi_sram_if.slave       bus
);

    localparam int unsigned           NumLanes = DATA_WIDTH / 8;
    localparam int unsigned           Words    = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] MemBytes = ADDR_WIDTH'(64'd8 << DEPTH_LOG2);
    // Holds RD_LATENCY-1 plus up to 3 extra delay cycles.
    localparam int unsigned           CntW     = $clog2(RD_LATENCY + 4);

    typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
    typedef enum logic [1:0] {StRIdle, StRWait, StRData} r_state_e;

    logic [DATA_WIDTH-1:0] mem [Words];

    // ---------------- write channel ----------------
    w_state_e              w_state_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [1:0]            b_resp_q;
    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [2:0]            w_sh;
    logic [DATA_WIDTH-1:0] w_data_sh;
    logic [NumLanes-1:0]   w_strb_sh;
    logic                  b_valid;

    assign w_off      = aw_addr_q - BASE_ADDR;
    assign w_in_range = w_off < MemBytes;
    assign w_idx      = w_off[DEPTH_LOG2+2:3];
    assign w_sh       = aw_addr_q[2:0];
    assign w_data_sh  = bus.w_data << {w_sh, 3'b000};
    // 8-bit shift: strobe bits pushed past lane 7 are dropped, never wrapped.
    assign w_strb_sh  = bus.w_strb << w_sh;

    // ---------------- read channel ----------------
    r_state_e              r_state_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [CntW-1:0]       r_cnt_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;
    logic [ADDR_WIDTH-1:0] r_off;
    logic                  r_in_range;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [2:0]            r_sh;
    logic [CntW-1:0]       r_cnt_init;

    assign r_off      = ar_addr_q - BASE_ADDR;
    assign r_in_range = r_off < MemBytes;
    assign r_idx      = r_off[DEPTH_LOG2+2:3];
    assign r_sh       = ar_addr_q[2:0];

`ifdef YSYX_22050019_AXI_SRAM_DELAY_EN
    logic [3:0] lfsr_q;
    logic [1:0] w_dly_q;

    // x^4 + x^3 + 1, free-running.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 4'b1001;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    assign r_cnt_init = CntW'(RD_LATENCY - 1) + CntW'(lfsr_q[1:0]);
    assign b_valid    = (w_state_q == StWResp) && (w_dly_q == 2'd0);
`else
    assign r_cnt_init = CntW'(RD_LATENCY - 1);
    assign b_valid    = (w_state_q == StWResp);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= StWIdle;
            aw_addr_q <= '0;
            b_resp_q  <= 2'b00;
`ifdef YSYX_22050019_AXI_SRAM_DELAY_EN
            w_dly_q   <= 2'd0;
`endif
        end else begin
            case (w_state_q)
                StWIdle: begin
                    if (bus.aw_valid) begin
                        aw_addr_q <= bus.aw_addr;
                        w_state_q <= StWData;
                    end
                end
                StWData: begin
                    if (bus.w_valid) begin
                        b_resp_q  <= w_in_range ? 2'b00 : 2'b11;
                        w_state_q <= StWResp;
`ifdef YSYX_22050019_AXI_SRAM_DELAY_EN
                        w_dly_q   <= lfsr_q[1:0];
`endif
                    end
                end
                StWResp: begin
`ifdef YSYX_22050019_AXI_SRAM_DELAY_EN
                    if (w_dly_q != 2'd0) begin
                        w_dly_q <= w_dly_q - 2'd1;
                    end
`endif
                    if (b_valid && bus.b_ready) begin
                        w_state_q <= StWIdle;
                    end
                end
                default: w_state_q <= StWIdle;
            endcase
        end
    end

    // Array is never reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && (w_state_q == StWData) && bus.w_valid && w_in_range) begin
            for (int i = 0; i < int'(NumLanes); i++) begin
                if (w_strb_sh[i]) begin
                    mem[w_idx][8*i +: 8] <= w_data_sh[8*i +: 8];
                end
            end
        end
    end

    // A capture on the same edge as a write commit sees the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= StRIdle;
            ar_addr_q <= '0;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
            r_resp_q  <= 2'b00;
        end else begin
            case (r_state_q)
                StRIdle: begin
                    if (bus.ar_valid) begin
                        ar_addr_q <= bus.ar_addr;
                        r_cnt_q   <= r_cnt_init;
                        r_state_q <= StRWait;
                    end
                end
                StRWait: begin
                    if (r_cnt_q == '0) begin
                        r_data_q  <= r_in_range ? (mem[r_idx] >> {r_sh, 3'b000}) : '0;
                        r_resp_q  <= r_in_range ? 2'b00 : 2'b11;
                        r_state_q <= StRData;
                    end else begin
                        r_cnt_q <= r_cnt_q - CntW'(1);
                    end
                end
                StRData: begin
                    if (bus.r_ready) begin
                        r_state_q <= StRIdle;
                    end
                end
                default: r_state_q <= StRIdle;
            endcase
        end
    end

    // Handshake outputs decode registered state only; rst forces them low
    // for the whole time reset is held.
    assign bus.aw_ready = !rst && (w_state_q == StWIdle);
    assign bus.w_ready  = !rst && (w_state_q == StWData);
    assign bus.b_valid  = !rst && b_valid;
    assign bus.b_resp   = b_resp_q;
    assign bus.ar_ready = !rst && (r_state_q == StRIdle);
    assign bus.r_valid  = !rst && (r_state_q == StRData);
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;

endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
module tb_ysyx_22050019_axi_sram;

    localparam int unsigned RdLatency = 1;
    localparam logic [63:0] RegBase   = 64'h8000_0100;

    logic clk;
    logic rst;

    ysyx_22050019_axi_sram_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    ysyx_22050019_axi_sram #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .DEPTH_LOG2(12),
        .BASE_ADDR (64'h8000_0000),
        .RD_LATENCY(RdLatency)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Byte-level reference of the 128-byte random-test window.
    logic [7:0] mb [128];

    typedef struct {
        logic        do_wr;
        logic [63:0] wa;
        logic [63:0] wd;
        logic [7:0]  ws;
        logic [1:0]  exp_b;
        logic [63:0] ra;
        logic [63:0] exp_r;
        logic [1:0]  exp_rr;
        int          hold;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int hold, output logic [1:0] resp);
        int n;
        bus.aw_addr  = a;
        bus.aw_valid = 1'b1;
        n = 0;
        while (bus.aw_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) check("aw_ready_timeout", 64'(bus.aw_ready), 64'd1);
        tick();
        bus.aw_valid = 1'b0;
        check("w_ready_after_aw", 64'(bus.w_ready), 64'd1);
        bus.w_data  = d;
        bus.w_strb  = s;
        bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        n = 0;
        while (bus.b_valid !== 1'b1 && n < 20) begin tick(); n++; end
        check("b_latency", 64'(n), 64'd0);
        resp = bus.b_resp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("b_valid_hold", 64'(bus.b_valid), 64'd1);
            check("b_resp_hold", 64'(bus.b_resp), 64'(resp));
            check("aw_ready_hold", 64'(bus.aw_ready), 64'd0);
        end
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        check("b_valid_after_b", 64'(bus.b_valid), 64'd0);
        check("aw_ready_after_b", 64'(bus.aw_ready), 64'd1);
    endtask

    task automatic axi_read(input logic [63:0] a, input int hold,
                            output logic [63:0] data, output logic [1:0] resp);
        int n;
        bus.ar_addr  = a;
        bus.ar_valid = 1'b1;
        n = 0;
        while (bus.ar_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) check("ar_ready_timeout", 64'(bus.ar_ready), 64'd1);
        tick();
        bus.ar_valid = 1'b0;
        n = 0;
        while (bus.r_valid !== 1'b1 && n < 20) begin tick(); n++; end
        check("r_latency", 64'(n), 64'(RdLatency));
        data = bus.r_data;
        resp = bus.r_resp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_valid_hold", 64'(bus.r_valid), 64'd1);
            check("r_data_hold", bus.r_data, data);
            check("ar_ready_hold", 64'(bus.ar_ready), 64'd0);
        end
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        check("r_valid_after_r", 64'(bus.r_valid), 64'd0);
        check("ar_ready_after_r", 64'(bus.ar_ready), 64'd1);
    endtask

    task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int bi;
        int sh;
        bi = int'(a - RegBase);
        sh = int'(a % 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (s[i] && (sh + i < 8)) mb[bi + i] = d[8*i +: 8];
        end
    endtask

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] r;
        int bi;
        int sh;
        r  = '0;
        bi = int'(a - RegBase);
        sh = int'(a % 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (sh + i < 8) r[8*i +: 8] = mb[bi + i];
        end
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_aw_ready"}, 64'(bus.aw_ready), 64'd0);
        check({tag, "_w_ready"}, 64'(bus.w_ready), 64'd0);
        check({tag, "_b_valid"}, 64'(bus.b_valid), 64'd0);
        check({tag, "_b_resp"}, 64'(bus.b_resp), 64'd0);
        check({tag, "_ar_ready"}, 64'(bus.ar_ready), 64'd0);
        check({tag, "_r_valid"}, 64'(bus.r_valid), 64'd0);
        check({tag, "_r_resp"}, 64'(bus.r_resp), 64'd0);
        check({tag, "_r_data"}, bus.r_data, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [63:0] data;
        logic [1:0]  rresp;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic        oor;
        int          hold;

        //             do_wr wa                wd                     ws     eb     ra                exp_r                  err    hold
        vecs[0]  = '{1'b1, 64'h8000_0000, 64'h1122334455667788, 8'hFF, 2'b00, 64'h8000_0000, 64'h1122334455667788, 2'b00, 5};
        vecs[1]  = '{1'b1, 64'h8000_0000, 64'h0,                8'hFF, 2'b00, 64'h8000_0000, 64'h0,                2'b00, 0};
        vecs[2]  = '{1'b1, 64'h8000_0003, 64'hAB,               8'h01, 2'b00, 64'h8000_0000, 64'h00000000AB000000, 2'b00, 0};
        vecs[3]  = '{1'b0, 64'h0,         64'h0,                8'h00, 2'b00, 64'h8000_0003, 64'h00000000000000AB, 2'b00, 1};
        vecs[4]  = '{1'b1, 64'h7FFF_FFF8, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'b11, 64'h7FFF_FFF8, 64'h0,                2'b11, 2};
        vecs[5]  = '{1'b0, 64'h0,         64'h0,                8'h00, 2'b00, 64'h8000_0000, 64'h00000000AB000000, 2'b00, 0};
        vecs[6]  = '{1'b1, 64'h8000_7FF8, 64'h0102030405060708, 8'hFF, 2'b00, 64'h8000_7FF8, 64'h0102030405060708, 2'b00, 0};
        vecs[7]  = '{1'b1, 64'h8000_8000, 64'h1234,             8'hFF, 2'b11, 64'h8000_8000, 64'h0,                2'b11, 0};
        vecs[8]  = '{1'b1, 64'h8000_0010, 64'h0,                8'hFF, 2'b00, 64'h8000_0010, 64'h0,                2'b00, 0};
        vecs[9]  = '{1'b1, 64'h8000_0018, 64'h0,                8'hFF, 2'b00, 64'h8000_0018, 64'h0,                2'b00, 0};
        vecs[10] = '{1'b1, 64'h8000_0016, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b00, 64'h8000_0010, 64'hFFFF000000000000, 2'b00, 0};
        vecs[11] = '{1'b0, 64'h0,         64'h0,                8'h00, 2'b00, 64'h8000_0018, 64'h0,                2'b00, 0};
        vecs[12] = '{1'b0, 64'h0,         64'h0,                8'h00, 2'b00, 64'h8000_0015, 64'h0000000000FFFF00, 2'b00, 0};
        vecs[13] = '{1'b1, 64'h8000_0000, 64'hA5A5A5A5A5A5A5A5, 8'h5A, 2'b00, 64'h8000_0000, 64'h00A500A5A500A500, 2'b00, 0};

        rst          = 1'b1;
        bus.aw_valid = 1'b0;
        bus.aw_addr  = '0;
        bus.w_valid  = 1'b0;
        bus.w_data   = '0;
        bus.w_strb   = '0;
        bus.b_ready  = 1'b0;
        bus.ar_valid = 1'b0;
        bus.ar_addr  = '0;
        bus.r_ready  = 1'b0;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("post_reset_aw_ready", 64'(bus.aw_ready), 64'd1);
        check("post_reset_ar_ready", 64'(bus.ar_ready), 64'd1);

        foreach (vecs[k]) begin
            if (vecs[k].do_wr) begin
                axi_write(vecs[k].wa, vecs[k].wd, vecs[k].ws, vecs[k].hold, resp);
                check($sformatf("vec%0d_b_resp", k), 64'(resp), 64'(vecs[k].exp_b));
            end
            axi_read(vecs[k].ra, vecs[k].hold, data, rresp);
            check($sformatf("vec%0d_r_data", k), data, vecs[k].exp_r);
            check($sformatf("vec%0d_r_resp", k), 64'(rresp), 64'(vecs[k].exp_rr));
        end

        // AR and AW to the same word in the same cycle: read captures on the
        // write-commit edge and must return the old word.
        bus.aw_addr  = 64'h8000_0000;
        bus.ar_addr  = 64'h8000_0000;
        bus.aw_valid = 1'b1;
        bus.ar_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0;
        bus.ar_valid = 1'b0;
        check("conc_w_ready", 64'(bus.w_ready), 64'd1);
        bus.w_data  = 64'h0123456789ABCDEF;
        bus.w_strb  = 8'hFF;
        bus.w_valid = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        check("conc_r_valid", 64'(bus.r_valid), 64'd1);
        check("conc_r_data_old", bus.r_data, 64'h00A500A5A500A500);
        check("conc_b_valid", 64'(bus.b_valid), 64'd1);
        check("conc_b_resp", 64'(bus.b_resp), 64'd0);
        bus.b_ready = 1'b1;
        bus.r_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        bus.r_ready = 1'b0;
        check("conc_aw_ready_back", 64'(bus.aw_ready), 64'd1);
        check("conc_ar_ready_back", 64'(bus.ar_ready), 64'd1);
        axi_read(64'h8000_0000, 0, data, rresp);
        check("conc_write_landed", data, 64'h0123456789ABCDEF);

        // Reset while in W_DATA with the W beat offered: write must be discarded.
        axi_write(64'h8000_0008, 64'h5555_6666_7777_8888, 8'hFF, 0, resp);
        bus.aw_addr  = 64'h8000_0008;
        bus.aw_valid = 1'b1;
        tick();
        bus.aw_valid = 1'b0;
        check("rst_wdata_w_ready", 64'(bus.w_ready), 64'd1);
        bus.w_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.w_strb  = 8'hFF;
        bus.w_valid = 1'b1;
        rst         = 1'b1;
        tick();
        bus.w_valid = 1'b0;
        check_reset_outputs("midrst");
        rst = 1'b0;
        #1;
        check("midrst_aw_ready_release", 64'(bus.aw_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_b_valid", 64'(bus.b_valid), 64'd0);
        end
        axi_read(64'h8000_0008, 0, data, rresp);
        check("midrst_word_unchanged", data, 64'h5555_6666_7777_8888);

        // Randomized traffic against the byte-level model.
        for (int w = 0; w < 16; w++) begin
            axi_write(RegBase + 64'(8 * w), 64'h0, 8'hFF, 0, resp);
            check("rand_init_b_resp", 64'(resp), 64'd0);
        end
        for (int i = 0; i < 128; i++) mb[i] = 8'h00;

        for (int it = 0; it < 80; it++) begin
            oor  = ($urandom_range(0, 7) == 0);
            hold = int'($urandom_range(0, 2));
            if (oor) begin
                if ($urandom_range(0, 1) == 1) a = 64'h8000_8000 + 64'($urandom_range(0, 255));
                else                           a = 64'h7FFF_FF00 + 64'($urandom_range(0, 255));
            end else begin
                a = RegBase + 64'($urandom_range(0, 127));
            end
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom};
                s = 8'($urandom_range(0, 255));
                axi_write(a, d, s, hold, resp);
                check("rand_b_resp", 64'(resp), oor ? 64'd3 : 64'd0);
                if (!oor) model_write(a, d, s);
            end else begin
                axi_read(a, hold, data, rresp);
                check("rand_r_resp", 64'(rresp), oor ? 64'd3 : 64'd0);
                check("rand_r_data", data, oor ? 64'd0 : model_read(a));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
